req_aging_ctrl: RTL and testbench

REQ_AGING_CTRL -- requirements
Module: req_aging_ctrl

---
 rtl/req_aging_pkg.sv | 14 +
 rtl/req_age_slot.sv | 72 +++++++
 rtl/req_aging_ctrl.sv | 76 +++++++
 tb/tb_req_aging_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/req_aging_pkg.sv
// Shared defaults and per-requester state encoding for the request aging controller.
package req_aging_pkg;

    localparam int N_DEF         = 8;
    localparam int AGE_W_DEF     = 4;
    localparam int AGE_LIMIT_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        URGENT = 2'd2
    } slot_state_e;

endpackage

// File: rtl/req_age_slot.sv
// One requester: pending/urgent state, saturating age counter, starve pulse.
// Latency: request/grant to state is one edge; starve is registered alongside the age.
module req_age_slot
    import req_aging_pkg::*;
#(
    parameter int AGE_W     = AGE_W_DEF,
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_urgent_i,
    input  logic grant_acc_i,
    output logic pending_o,
    output logic urgent_o,
    output logic pending_nxt_o,
    output logic starve_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

    slot_state_e      state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             starve_q, starve_d;
    logic             can_load;

    // A slot accepts a new request when idle or when its grant is accepted this cycle.
    assign can_load = (state_q == IDLE) || grant_acc_i;

    always_comb begin
        state_d  = state_q;
        age_d    = age_q;
        starve_d = 1'b0;
        if (req_urgent_i && can_load) begin
            state_d = URGENT;
            age_d   = '0;
        end else if (req_i && can_load) begin
            state_d = WAIT;
            age_d   = '0;
        end else if (grant_acc_i) begin
            state_d = IDLE;
            age_d   = '0;
        end else if (state_q != IDLE) begin
            if (age_q != AGE_MAX) begin
                age_d = age_q + 1'b1;
            end
            if (req_urgent_i || (age_d == AGE_LIM)) begin
                state_d = URGENT;
            end
            starve_d = (age_d == AGE_MAX) && (age_q != AGE_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            age_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            starve_q <= starve_d;
        end
    end

    assign pending_o     = (state_q != IDLE);
    assign urgent_o      = (state_q == URGENT);
    assign pending_nxt_o = (state_d != IDLE);
    assign starve_o      = starve_q;

endmodule

// File: rtl/req_aging_ctrl.sv
// Ages N pending requests, promotes old ones to urgent and validates the selector grant.
// Latency: req -> ready one cycle; no backpressure, illegal grants are flagged and dropped.
module req_aging_ctrl
    import req_aging_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int AGE_W     = AGE_W_DEF,
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_in,
    input  logic [N-1:0]           req_urgent_in,
    input  logic [N-1:0]           grant,
    input  logic                   grant_valid,
    output logic [N-1:0]           ready,
    output logic [N-1:0]           ready_urgent,
    output logic [$clog2(N+1)-1:0] pending_cnt,
    output logic [N-1:0]           starve,
    output logic                   grant_err
);

    localparam int CNT_W = $clog2(N+1);

    logic [N-1:0]     pending, urgent, pending_nxt, grant_acc;
    logic             grant_onehot, grant_hit, grant_ok;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_err_q, grant_err_d;

    assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    assign grant_hit    = |(grant & pending);
    assign grant_ok     = grant_valid && grant_onehot && grant_hit;
    assign grant_acc    = grant_ok ? grant : '0;
    assign grant_err_d  = grant_err_q | (grant_valid & ~(grant_onehot & grant_hit));

    for (genvar i = 0; i < N; i++) begin : g_slot
        req_age_slot #(
            .AGE_W     (AGE_W),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_i         (req_in[i]),
            .req_urgent_i  (req_urgent_in[i]),
            .grant_acc_i   (grant_acc[i]),
            .pending_o     (pending[i]),
            .urgent_o      (urgent[i]),
            .pending_nxt_o (pending_nxt[i]),
            .starve_o      (starve[i])
        );
    end

    // Count the next-state vector so the registered count lines up with ready.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + CNT_W'(pending_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            grant_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign ready        = pending;
    assign ready_urgent = urgent;
    assign pending_cnt  = cnt_q;
    assign grant_err    = grant_err_q;

endmodule

// File: tb/tb_req_aging_ctrl.sv
// Directed vector bench for req_aging_ctrl with hand-computed expectations.
module tb_req_aging_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in, req_urgent_in, grant;
    logic       grant_valid;
    logic [7:0] ready, ready_urgent, starve;
    logic [3:0] pending_cnt;
    logic       grant_err;

    int n_checks = 0;
    int n_fail   = 0;

    req_aging_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .req_urgent_in (req_urgent_in),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .ready         (ready),
        .ready_urgent  (ready_urgent),
        .pending_cnt   (pending_cnt),
        .starve        (starve),
        .grant_err     (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] urg;
        logic [7:0] gnt;
        logic       gv;
        logic [7:0] e_rdy;
        logic [7:0] e_rdyu;
        logic [3:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] u, input logic [7:0] g, input logic gv);
        req_in        = r;
        req_urgent_in = u;
        grant         = g;
        grant_valid   = gv;
    endtask

    task automatic do_reset();
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"},        32'(ready),        32'h0);
        chk({tag, " ready_urgent"}, 32'(ready_urgent), 32'h0);
        chk({tag, " pending_cnt"},  32'(pending_cnt),  32'h0);
        chk({tag, " starve"},       32'(starve),       32'h0);
        chk({tag, " grant_err"},    32'(grant_err),    32'h0);
    endtask

    initial begin
        // Bit 2 is requested first and ages through the whole table; it reaches age 10 at vector 10.
        //          req     urg     gnt     gv    rdy     rdyu    cnt   err
        tbl[0]  = '{8'h04, 8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 4'd1, 1'b0};
        tbl[1]  = '{8'h38, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h00, 4'd4, 1'b0};
        tbl[2]  = '{8'h00, 8'h00, 8'h08, 1'b1, 8'h34, 8'h00, 4'd3, 1'b0};
        tbl[3]  = '{8'h00, 8'h02, 8'h00, 1'b0, 8'h36, 8'h02, 4'd4, 1'b0};
        tbl[4]  = '{8'h02, 8'h00, 8'h02, 1'b1, 8'h36, 8'h00, 4'd4, 1'b0};
        tbl[5]  = '{8'h00, 8'h00, 8'h01, 1'b0, 8'h36, 8'h00, 4'd4, 1'b0};
        tbl[6]  = '{8'h04, 8'h10, 8'h00, 1'b0, 8'h36, 8'h10, 4'd4, 1'b0};
        tbl[7]  = '{8'h00, 8'h00, 8'h03, 1'b1, 8'h36, 8'h10, 4'd4, 1'b1};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h36, 8'h10, 4'd4, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 8'h20, 1'b1, 8'h16, 8'h10, 4'd3, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h16, 8'h14, 4'd3, 1'b1};

        rst_n = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        #3;
        chk_all_zero("reset");
        do_reset();

        for (int v = 0; v < 11; v++) begin
            drive(tbl[v].req, tbl[v].urg, tbl[v].gnt, tbl[v].gv);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ready", v),        32'(ready),        32'(tbl[v].e_rdy));
            chk($sformatf("vec%0d ready_urgent", v), 32'(ready_urgent), 32'(tbl[v].e_rdyu));
            chk($sformatf("vec%0d pending_cnt", v),  32'(pending_cnt),  32'(tbl[v].e_cnt));
            chk($sformatf("vec%0d grant_err", v),    32'(grant_err),    32'(tbl[v].e_err));
            chk($sformatf("vec%0d starve", v),       32'(starve),       32'h0);
        end
        drive(8'h00, 8'h00, 8'h00, 1'b0);

        // Single requester aging: promotion at age 10, one starve pulse at age 15, then silence.
        do_reset();
        drive(8'h04, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        chk("age0 ready", 32'(ready), 32'h04);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("age%0d ready_urgent", k), 32'(ready_urgent), (k >= 10) ? 32'h04 : 32'h00);
            chk($sformatf("age%0d starve", k),       32'(starve),       (k == 15) ? 32'h04 : 32'h00);
        end

        // One-hot grant to a requester that is not pending.
        do_reset();
        drive(8'h04, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(8'h00, 8'h00, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        chk("nonpend grant_err", 32'(grant_err),   32'h1);
        chk("nonpend ready",     32'(ready),       32'h04);
        chk("nonpend cnt",       32'(pending_cnt), 32'h1);
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("sticky grant_err",  32'(grant_err),   32'h1);

        // Asynchronous reset between edges, then capture on the first edge after release.
        do_reset();
        drive(8'h38, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        chk("pre-arst ready", 32'(ready),       32'h38);
        chk("pre-arst cnt",   32'(pending_cnt), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        #1 rst_n = 1'b1;
        drive(8'h01, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        chk("post-arst ready", 32'(ready),       32'h01);
        chk("post-arst cnt",   32'(pending_cnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
